// File: rtl/mag_comp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator family.
package mag_comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result one-hot, packed as {gt, lt, eq}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b100;

    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mag_bit_step.sv
// Single-bit compare step: flags a differing bit and which operand it favours.
// In signed mode the MSB carries negative weight, so its polarity is inverted.
module mag_bit_step (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic signed_mode,
    output logic differ,
    output logic a_greater
);

    always_comb begin
        differ    = a_bit ^ b_bit;
        a_greater = (is_msb && signed_mode) ? b_bit : a_bit;
    end

endmodule

// File: rtl/mag_comp_serial.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's-complement per operation.
// Result registers hold the last outcome until the next compare finishes.
module mag_comp_serial
    import mag_comp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             a_gt_q, a_gt_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;

    logic             bit_differ;
    logic             bit_a_greater;
    logic             finish;

    mag_bit_step u_step (
        .a_bit       (a_q[idx_q]),
        .b_bit       (b_q[idx_q]),
        .is_msb      (idx_q == IDX_MAX),
        .signed_mode (sm_q),
        .differ      (bit_differ),
        .a_greater   (bit_a_greater)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sm_d      = sm_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        a_gt_d    = a_gt_q;
        res_d     = res_q;
        done_d    = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    sm_d      = signed_mode;
                    idx_d     = IDX_MAX;
                    decided_d = 1'b0;
                    a_gt_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Only the first differing bit from the MSB decides; later ones are ignored.
                if (!decided_q && bit_differ) begin
                    decided_d = 1'b1;
                    a_gt_d    = bit_a_greater;
                end
                finish = (idx_q == '0) || ((EARLY_EXIT != 0) && bit_differ);
                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (decided_d) begin
                        res_d = a_gt_d ? RES_GT : RES_LT;
                    end else begin
                        res_d = RES_EQ;
                    end
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sm_q      <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            a_gt_q    <= 1'b0;
            res_q     <= RES_NONE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sm_q      <= sm_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            a_gt_q    <= a_gt_d;
            res_q     <= res_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign eq   = res_q[0];
    assign lt   = res_q[1];
    assign gt   = res_q[2];

endmodule

// File: tb/tb_mag_comp_serial.sv
// Bench for mag_comp_serial: fixed-latency and early-exit instances checked against a arithmetic reference.
module tb_mag_comp_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic busy0, done0, eq0, lt0, gt0;
    logic busy1, done1, eq1, lt1, gt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mag_comp_serial #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(sm), .a(a), .b(b),
        .busy(busy0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0)
    );

    mag_comp_serial #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(sm), .a(a), .b(b),
        .busy(busy1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1)
    );

    // Reference: plain integer comparison, result as {gt,lt,eq}
    function automatic logic [2:0] model_res(input logic [7:0] ma, input logic [7:0] mb, input logic msm);
        int va, vb;
        va = msm ? int'($signed(ma)) : int'(ma);
        vb = msm ? int'($signed(mb)) : int'(mb);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_lat(input logic [7:0] ma, input logic [7:0] mb, input bit ee);
        logic [7:0] x;
        x = ma ^ mb;
        if (!ee || x == 8'h00) return 8;
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) return 8 - i;
        end
        return 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] res_of(input bit ee);
        return ee ? {gt1, lt1, eq1} : {gt0, lt0, eq0};
    endfunction

    // Starts a compare; returns cycles from accept edge to done (-1 on timeout)
    // and the number of busy-high samples before done.
    task automatic run_cmp(input bit ee, input logic [7:0] ia, input logic [7:0] ib, input logic ism,
                           output int lat, output int busy_cnt, output logic [2:0] res);
        a = ia; b = ib; sm = ism;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        a = $urandom; b = $urandom; sm = $urandom;
        lat = -1;
        busy_cnt = (ee ? busy1 : busy0) ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ee ? done1 : done0) begin
                lat = n;
                break;
            end
            if (ee ? busy1 : busy0) busy_cnt++;
        end
        res = res_of(ee);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy0, done0, eq0, lt0, gt0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_dut0 got=%b want=00000", {busy0, done0, eq0, lt0, gt0});
        end
        checks++;
        if ({busy1, done1, eq1, lt1, gt1} !== 5'b0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b want=00000", {busy1, done1, eq1, lt1, gt1});
        end
    endtask

    task automatic test_directed(input bit ee, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ism, input string name);
        int lat, bc;
        logic [2:0] res;
        run_cmp(ee, ia, ib, ism, lat, bc, res);
        checks++;
        if (lat !== model_lat(ia, ib, ee)) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, model_lat(ia, ib, ee));
        end
        checks++;
        if (res !== model_res(ia, ib, ism)) begin
            failures++;
            $display("FAIL %s_result got=%b want=%b", name, res, model_res(ia, ib, ism));
        end
        checks++;
        if (bc !== model_lat(ia, ib, ee)) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, model_lat(ia, ib, ee));
        end
        checks++;
        if ((ee ? busy1 : busy0) !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_at_done got=1 want=0", name);
        end
        tick();
        checks++;
        if ((ee ? done1 : done0) !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_one_cycle got=1 want=0", name);
        end
    endtask

    task automatic test_random(input bit ee, input int count);
        int lat, bc;
        logic [7:0] ra, rb;
        logic rsm;
        logic [2:0] res;
        for (int k = 0; k < count; k++) begin
            ra = $urandom; rb = $urandom; rsm = $urandom;
            if (k % 5 == 0) rb = ra;
            else if (k % 5 == 1) rb = ra ^ (8'h01 << $urandom_range(7, 0));
            run_cmp(ee, ra, rb, rsm, lat, bc, res);
            checks++;
            if (lat !== model_lat(ra, rb, ee) || res !== model_res(ra, rb, rsm)) begin
                failures++;
                $display("FAIL random_ee%0d a=%h b=%h s=%0d lat=%0d res=%b want lat=%0d res=%b",
                         ee, ra, rb, rsm, lat, res, model_lat(ra, rb, ee), model_res(ra, rb, rsm));
            end
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt, done_at;
        a = 8'h40; b = 8'h20; sm = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        done_cnt = 0; done_at = -1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin
                a = 8'h00; b = 8'hFF; start0 = 1'b1;
            end
            tick();
            start0 = 1'b0;
            if (done0) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
                checks++;
                if ({gt0, lt0, eq0} !== 3'b100) begin
                    failures++;
                    $display("FAIL ignore_start_result got=%b want=100", {gt0, lt0, eq0});
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 8) begin
            failures++;
            $display("FAIL ignore_start_done got count=%0d at=%0d want count=1 at=8", done_cnt, done_at);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, lat2;
        logic [2:0] res;
        run_cmp(1'b0, 8'h30, 8'h10, 1'b0, lat, bc, res);
        checks++;
        if (res !== 3'b100) begin
            failures++;
            $display("FAIL b2b_first got=%b want=100", res);
        end
        // still in the done cycle: issue the next compare immediately
        a = 8'h10; b = 8'h20; sm = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept busy got=%b want=1", busy0);
        end
        lat2 = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done0) begin
                lat2 = n;
                break;
            end
            checks++;
            if ({gt0, lt0, eq0} !== 3'b100) begin
                failures++;
                $display("FAIL b2b_hold n=%0d got=%b want=100", n, {gt0, lt0, eq0});
            end
        end
        checks++;
        if (lat2 !== 8 || {gt0, lt0, eq0} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_second lat=%0d res=%b want lat=8 res=010", lat2, {gt0, lt0, eq0});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        a = 8'h7F; b = 8'h01; sm = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy0, done0, eq0, lt0, gt0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_clear got=%b want=00000", {busy0, done0, eq0, lt0, gt0});
        end
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done0 || busy0) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet got=%0d active cycles want=0", done_cnt);
        end
        test_directed(1'b0, 8'h11, 8'h22, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed(1'b0, 8'h5A, 8'h5A, 1'b0, "eq_5a");
        test_directed(1'b0, 8'h80, 8'h01, 1'b0, "unsigned_80_01");
        test_directed(1'b0, 8'h80, 8'h01, 1'b1, "signed_80_01");
        test_directed(1'b1, 8'h80, 8'h00, 1'b0, "ee_80_00");
        test_directed(1'b1, 8'h03, 8'h02, 1'b0, "ee_03_02");
        test_directed(1'b1, 8'hFF, 8'hFF, 1'b0, "ee_ff_ff");
        test_directed(1'b1, 8'h01, 8'hFF, 1'b1, "ee_signed_01_ff");
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random(1'b0, 30);
        test_random(1'b1, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
